// File: rtl/kogge_stone_adder_pkg.sv
// Shared helpers for the Kogge-Stone adder: prefix-tree depth for a given width.
package kogge_stone_adder_pkg;

    localparam int DEFAULT_PRECISION = 8;

    // Number of prefix levels: ceil(log2(width)), 0 for width 1.
    function automatic int ks_levels(input int width);
        int levels;
        levels = 0;
        while ((1 << levels) < width) begin
            levels = levels + 1;
        end
        return levels;
    endfunction

endpackage

// File: rtl/kogge_stone_adder_prefix_cell.sv
// Kogge-Stone black cell: merges a high (generate, propagate) group with the group below it.
module ks_prefix_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;

endmodule

// File: rtl/kogge_stone_adder.sv
// Registered unsigned adder with a log-depth Kogge-Stone carry network, carry-in tied to 0.
module kogge_stone_adder
    import kogge_stone_adder_pkg::*;
#(
    parameter int PRECISION = DEFAULT_PRECISION
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PRECISION-1:0] operand_a_i,
    input  logic [PRECISION-1:0] operand_b_i,
    output logic [PRECISION-1:0] result_o,
    output logic                 overflow_o
);

    localparam int LEVELS = ks_levels(PRECISION);

    // Level 0 holds the per-bit generate/propagate; level LEVELS holds group terms from bit 0.
    logic [PRECISION-1:0] g_lvl [LEVELS+1];
    logic [PRECISION-1:0] p_lvl [LEVELS+1];

    logic [PRECISION-1:0] bit_p;
    logic [PRECISION-1:0] carry;
    logic [PRECISION-1:0] sum;
    logic                 carry_out;

    assign bit_p    = operand_a_i ^ operand_b_i;
    assign g_lvl[0] = operand_a_i & operand_b_i;
    assign p_lvl[0] = bit_p;

    genvar k, i;
    generate
        for (k = 0; k < LEVELS; k++) begin : g_level
            localparam int DIST = 1 << k;
            for (i = 0; i < PRECISION; i++) begin : g_bit
                if (i >= DIST) begin : g_cell
                    ks_prefix_cell u_cell (
                        .g_hi  (g_lvl[k][i]),
                        .p_hi  (p_lvl[k][i]),
                        .g_lo  (g_lvl[k][i-DIST]),
                        .p_lo  (p_lvl[k][i-DIST]),
                        .g_out (g_lvl[k+1][i]),
                        .p_out (p_lvl[k+1][i])
                    );
                end else begin : g_pass
                    assign g_lvl[k+1][i] = g_lvl[k][i];
                    assign p_lvl[k+1][i] = p_lvl[k][i];
                end
            end
        end

        // Carry into bit i is the group generate of bits [i-1:0]; bit 0 sees carry-in 0.
        if (PRECISION == 1) begin : g_carry_single
            assign carry = 1'b0;
        end else begin : g_carry_multi
            assign carry = {g_lvl[LEVELS][PRECISION-2:0], 1'b0};
        end
    endgenerate

    assign sum       = bit_p ^ carry;
    assign carry_out = g_lvl[LEVELS][PRECISION-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o   <= '0;
            overflow_o <= 1'b0;
        end else begin
            result_o   <= sum;
            overflow_o <= carry_out;
        end
    end

endmodule

// File: tb/tb_kogge_stone_adder.sv
// Directed and sweep bench for kogge_stone_adder at widths 8, 1, 5 and 16.
module tb_kogge_stone_adder;

    logic clk;
    logic rst;

    logic [7:0]  a8,  b8,  r8;
    logic        o8;
    logic        a1,  b1,  r1;
    logic        o1;
    logic [4:0]  a5,  b5,  r5;
    logic        o5;
    logic [15:0] a16, b16, r16;
    logic        o16;

    int errors;
    int checks;

    kogge_stone_adder #(.PRECISION(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .operand_a_i(a8), .operand_b_i(b8),
        .result_o(r8), .overflow_o(o8)
    );
    kogge_stone_adder #(.PRECISION(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .operand_a_i(a1), .operand_b_i(b1),
        .result_o(r1), .overflow_o(o1)
    );
    kogge_stone_adder #(.PRECISION(5)) dut5 (
        .clk_i(clk), .rst_i(rst), .operand_a_i(a5), .operand_b_i(b5),
        .result_o(r5), .overflow_o(o5)
    );
    kogge_stone_adder #(.PRECISION(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .operand_a_i(a16), .operand_b_i(b16),
        .result_o(r16), .overflow_o(o16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] observed, input logic [16:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one 8-bit pair, advance one edge, compare {ovf,result} to a hand value.
    task automatic step8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] expected);
        a8 = a;
        b8 = b;
        tick();
        check(tag, {8'h0, o8, r8}, {8'h0, expected});
    endtask

    initial begin
        logic [16:0] exp_w;
        errors = 0;
        checks = 0;
        a1 = 1'b1; b1 = 1'b1; a5 = 5'h1f; b5 = 5'h1f; a16 = 16'hffff; b16 = 16'hffff;

        // Reset held two cycles with busy operands
        rst = 1'b1;
        a8 = 8'hAA;
        b8 = 8'h55;
        tick();
        check("reset_c1", {8'h0, o8, r8}, 17'h0);
        tick();
        check("reset_c2", {8'h0, o8, r8}, 17'h0);
        check("reset_w1",  {15'h0, o1, r1},  17'h0);
        check("reset_w5",  {11'h0, o5, r5},  17'h0);
        check("reset_w16", {o16, r16},       17'h0);
        rst = 1'b0;

        // Directed sums
        step8("add_0_0",     8'd0,   8'd0,   {1'b0, 8'd0});
        step8("add_10_25",   8'd10,  8'd25,  {1'b0, 8'd35});
        step8("add_88_42",   8'd88,  8'd42,  {1'b0, 8'd130});
        step8("add_255_0",   8'd255, 8'd0,   {1'b0, 8'd255});
        step8("add_255_1",   8'd255, 8'd1,   {1'b1, 8'd0});
        step8("add_150_150", 8'd150, 8'd150, {1'b1, 8'd44});
        step8("add_ff_ff",   8'd255, 8'd255, {1'b1, 8'd254});

        // Registered output: changing operands between edges must not disturb outputs
        a8 = 8'd7;
        b8 = 8'd9;
        #2;
        check("hold_between_edges", {8'h0, o8, r8}, {8'h0, 1'b1, 8'd254});

        // Back-to-back streaming
        step8("stream_255_1",   8'd255, 8'd1,   {1'b1, 8'd0});
        step8("stream_1_1",     8'd1,   8'd1,   {1'b0, 8'd2});
        step8("stream_128_128", 8'd128, 8'd128, {1'b1, 8'd0});

        // Reset mid-stream discards 200+100
        a8 = 8'd200;
        b8 = 8'd100;
        rst = 1'b1;
        tick();
        check("midreset_discard", {8'h0, o8, r8}, 17'h0);
        rst = 1'b0;
        step8("after_reset_3_4", 8'd3, 8'd4, {1'b0, 8'd7});

        // Exhaustive 8-bit
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                a8 = a[7:0];
                b8 = b[7:0];
                tick();
                exp_w = 17'(a + b);
                check("exhaustive", {8'h0, o8, r8}, exp_w);
            end
        end

        // Random 8-bit
        for (int n = 0; n < 1000; n++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            exp_w = {9'h0, a8} + {9'h0, b8};
            tick();
            check("random8", {8'h0, o8, r8}, exp_w);
        end

        // Width sweep: all-ones + 1 at each width
        a1 = 1'b1;     b1 = 1'b1;
        a5 = 5'h1f;    b5 = 5'h01;
        a16 = 16'hffff; b16 = 16'h0001;
        tick();
        check("w1_ones_plus_1",  {15'h0, o1, r1}, {15'h0, 1'b1, 1'b0});
        check("w5_ones_plus_1",  {11'h0, o5, r5}, {11'h0, 1'b1, 5'h00});
        check("w16_ones_plus_1", {o16, r16},      {1'b1, 16'h0000});

        a1 = 1'b1;  b1 = 1'b0;
        a5 = 5'd19; b5 = 5'd9;
        a16 = 16'h8000; b16 = 16'h7fff;
        tick();
        check("w1_1_0",      {15'h0, o1, r1}, {15'h0, 1'b0, 1'b1});
        check("w5_19_9",     {11'h0, o5, r5}, {11'h0, 1'b0, 5'd28});
        check("w16_carry_chain", {o16, r16},  {1'b0, 16'hffff});

        for (int n = 0; n < 300; n++) begin
            a1  = 1'($urandom_range(0, 1));
            b1  = 1'($urandom_range(0, 1));
            a5  = 5'($urandom_range(0, 31));
            b5  = 5'($urandom_range(0, 31));
            a16 = 16'($urandom_range(0, 65535));
            b16 = 16'($urandom_range(0, 65535));
            tick();
            check("random_w1",  {15'h0, o1, r1}, {15'h0, ({1'b0, a1} + {1'b0, b1})});
            check("random_w5",  {11'h0, o5, r5}, {11'h0, ({1'b0, a5} + {1'b0, b5})});
            check("random_w16", {o16, r16},      ({1'b0, a16} + {1'b0, b16}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
